regfile_mp: RTL and testbench

- Parametrised multi-port integer register file; successor to the single-write, two-read RV32I register file in the decode stage.
- Adds configurable read/write port counts, width and depth, with register 0 hardwired to zero.
- Adds a sequential scrub engine that zeroes the array after reset or on demand; `busy_o` stalls the pipeline while it runs.
- Replaces file-based init/dump; no `$readmemh`/`$writememh` in synthesizable code.

---
 rtl/regfile_mp_pkg.sv | 25 ++
 rtl/regfile_mp_scrub.sv | 53 +++++
 rtl/regfile_mp.sv | 82 ++++++++
 tb/tb_regfile_mp.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_mp_pkg.sv
// Shared types, default sizes and write-port priority helper for regfile_mp.
package regfile_mp_pkg;

   localparam int unsigned RF_XLEN_DEF = 32;
   localparam int unsigned RF_NREG_DEF = 32;

   typedef enum logic [0:0] {
      RF_IDLE  = 1'b0,
      RF_SCRUB = 1'b1
   } rf_state_e;

   typedef struct packed {
      logic vld;
      logic idx;
   } rf_pick_t;

   // Highest-numbered hitting write port wins a same-address collision.
   function automatic rf_pick_t rf_pick_port(input logic [1:0] hit);
      rf_pick_t p;
      p.vld = |hit;
      p.idx = hit[1];
      return p;
   endfunction

endpackage

// File: rtl/regfile_mp_scrub.sv
// Scrub engine for regfile_mp: walks x1..x(NREG-1) writing zero after reset or on clear_i.
module regfile_mp_scrub
   import regfile_mp_pkg::*;
#(
   parameter  int unsigned NREG = RF_NREG_DEF,
   localparam int unsigned AW   = $clog2(NREG)
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic          clear_i,
   output logic          busy_o,
   output logic          swe_o,
   output logic [AW-1:0] saddr_o
);

   rf_state_e     state_q, state_d;
   logic [AW-1:0] ptr_q, ptr_d;

   // NOTE: next-state defaults come first so no path leaves a value unassigned (no latch).
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      case (state_q)
         RF_IDLE: begin
            if (clear_i) begin
               state_d = RF_SCRUB;
               ptr_d   = AW'(1);
            end
         end
         RF_SCRUB: begin
            if (ptr_q == AW'(NREG - 1)) state_d = RF_IDLE;
            else                        ptr_d   = ptr_q + AW'(1);
         end
         default: state_d = RF_IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= RF_SCRUB;
         ptr_q   <= AW'(1);
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
      end
   end

   assign busy_o  = (state_q == RF_SCRUB);
   assign swe_o   = busy_o;
   assign saddr_o = ptr_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file, x0 hardwired to zero, with scrub-on-reset/clear.
// Define REGFILE_MP_BYPASS_EN to forward same-cycle writes to matching read ports.
module regfile_mp
   import regfile_mp_pkg::*;
#(
   parameter  int unsigned XLEN = RF_XLEN_DEF,
   parameter  int unsigned NREG = RF_NREG_DEF,
   parameter  int unsigned NRD  = 2,
   parameter  int unsigned NWR  = 1,
   localparam int unsigned AW   = $clog2(NREG)
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic [NRD*AW-1:0]   raddr_i,
   output logic [NRD*XLEN-1:0] rdata_o,
   input  logic [NWR*AW-1:0]   waddr_i,
   input  logic [NWR*XLEN-1:0] wdata_i,
   input  logic [NWR-1:0]      wen_i,
   input  logic                clear_i,
   output logic                busy_o
);

   logic            scrub_we;
   logic [AW-1:0]   scrub_addr;
   logic [XLEN-1:0] regs_q  [NREG];
   rf_pick_t        wr_pick [NREG];
   logic [AW-1:0]   rd_addr;
   logic [XLEN-1:0] rd_data;

   regfile_mp_scrub #(.NREG(NREG)) u_scrub (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .clear_i (clear_i),
      .busy_o  (busy_o),
      .swe_o   (scrub_we),
      .saddr_o (scrub_addr)
   );

   function automatic logic [1:0] port_hits(input logic [NWR-1:0]    wen,
                                            input logic [NWR*AW-1:0] waddr,
                                            input logic [AW-1:0]     a);
      logic [1:0] h;
      h = '0;
      for (int j = 0; j < NWR; j++)
         h[j] = wen[j] && (waddr[j*AW +: AW] == a) && (a != '0);
      return h;
   endfunction

   always_comb begin
      for (int r = 0; r < NREG; r++)
         wr_pick[r] = rf_pick_port(port_hits(wen_i, waddr_i, AW'(r)));
   end

   // NOTE: the array has no reset; the scrub engine zeroes it after reset instead.
   always_ff @(posedge clk_i) begin
      for (int r = 1; r < NREG; r++) begin
         if (scrub_we) begin
            if (scrub_addr == AW'(r)) regs_q[r] <= '0;
         end else if (wr_pick[r].vld) begin
            regs_q[r] <= wdata_i[int'(wr_pick[r].idx)*XLEN +: XLEN];
         end
      end
   end

   always_comb begin
      rdata_o = '0;
      rd_addr = '0;
      rd_data = '0;
      for (int k = 0; k < NRD; k++) begin
         rd_addr = raddr_i[k*AW +: AW];
         rd_data = regs_q[rd_addr];
`ifdef REGFILE_MP_BYPASS_EN
         if (wr_pick[rd_addr].vld)
            rd_data = wdata_i[int'(wr_pick[rd_addr].idx)*XLEN +: XLEN];
`endif
         // x0 is never stored, and a scrub in progress hides partially cleared contents.
         if (busy_o || rd_addr == '0) rd_data = '0;
         rdata_o[k*XLEN +: XLEN] = rd_data;
      end
   end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp (NRD=2, NWR=2) against a behavioural model.
module tb_regfile_mp;

   localparam int XLEN = 32;
   localparam int NREG = 32;
   localparam int AW   = 5;

   logic            clk_i  = 1'b0;
   logic            rst_ni = 1'b0;
   logic [AW-1:0]   ra [2];
   logic [AW-1:0]   wa [2];
   logic [31:0]     wd [2];
   logic [1:0]      wen;
   logic            clear;
   logic            check_en = 1'b0;

   logic [2*AW-1:0]   raddr;
   logic [2*AW-1:0]   waddr;
   logic [2*XLEN-1:0] wdata;
   logic [2*XLEN-1:0] rdata;
   logic              busy;

   assign raddr = {ra[1], ra[0]};
   assign waddr = {wa[1], wa[0]};
   assign wdata = {wd[1], wd[0]};

   regfile_mp #(.XLEN(XLEN), .NREG(NREG), .NRD(2), .NWR(2)) dut (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .raddr_i (raddr),
      .rdata_o (rdata),
      .waddr_i (waddr),
      .wdata_i (wdata),
      .wen_i   (wen),
      .clear_i (clear),
      .busy_o  (busy)
   );

   always #5 clk_i = ~clk_i;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
   endtask

   // Model: a scrub makes every register zero at once and blocks the array for NREG-1 edges.
   logic [31:0] mem [NREG];
   int          busy_left = NREG - 1;

   always @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         busy_left <= NREG - 1;
         for (int i = 0; i < NREG; i++) mem[i] <= '0;
      end else if (busy_left > 0) begin
         busy_left <= busy_left - 1;
      end else begin
         for (int j = 0; j < 2; j++)
            if (wen[j] && wa[j] != '0) mem[wa[j]] <= wd[j];
         if (clear) begin
            busy_left <= NREG - 1;
            for (int i = 0; i < NREG; i++) mem[i] <= '0;
         end
      end
   end

   function automatic logic [31:0] exp_rd(input int k);
      logic [31:0] v;
      if (busy_left > 0 || ra[k] == '0) return '0;
      v = mem[ra[k]];
`ifdef REGFILE_MP_BYPASS_EN
      if (wen[0] && wa[0] == ra[k]) v = wd[0];
      if (wen[1] && wa[1] == ra[k]) v = wd[1];
`endif
      return v;
   endfunction

   always @(negedge clk_i) begin
      if (check_en) begin
         check("busy", {31'b0, busy}, {31'b0, (busy_left > 0)});
         for (int k = 0; k < 2; k++)
            check($sformatf("rdata%0d@x%0d", k, ra[k]), rdata[k*32 +: 32], exp_rd(k));
      end
   end

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic count_busy(input string name, input int exp_cycles);
      int cnt;
      cnt = 0;
      while (busy === 1'b1 && cnt < 100) begin
         tick();
         cnt++;
      end
      check(name, cnt, exp_cycles);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
      $fatal(1, "timeout");
   end

   initial begin
      ra[0] = 5; ra[1] = 9; wa[0] = 0; wa[1] = 0; wd[0] = 0; wd[1] = 0;
      wen = 2'b00; clear = 1'b0;
      repeat (3) tick();
      check_en = 1'b1;
      #2;
      check("busy_in_reset", {31'b0, busy}, 32'd1);
      check("rd_in_reset", rdata[31:0], 32'h0);

      rst_ni = 1'b1;
      count_busy("busy_after_reset", 31);

      for (int i = 1; i < NREG; i++) begin
         ra[0] = AW'(i);
         ra[1] = AW'(NREG - i);
         tick();
      end
      ra[0] = 17; #2;
      check("x17_after_scrub", rdata[31:0], 32'h0);

      tick();
      wa[0] = 5; wd[0] = 32'hDEADBEEF; wen = 2'b01; ra[0] = 5; ra[1] = 0;
      tick();
      wen = 2'b00; #2;
      check("x5_read", rdata[31:0], 32'hDEADBEEF);
      check("x0_read_p1", rdata[63:32], 32'h0);

      tick();
      wa[0] = 3; wd[0] = 32'hA5A5A5A5; wen = 2'b01; ra[0] = 3; #2;
`ifdef REGFILE_MP_BYPASS_EN
      check("x3_same_cycle", rdata[31:0], 32'hA5A5A5A5);
`else
      check("x3_same_cycle", rdata[31:0], 32'h0);
`endif
      tick();
      wen = 2'b00; #2;
      check("x3_next_cycle", rdata[31:0], 32'hA5A5A5A5);

      tick();
      wa[0] = 0; wd[0] = 32'h12345678; wen = 2'b01; ra[0] = 0; ra[1] = 0;
      tick();
      wen = 2'b00; #2;
      check("x0_write_p0", rdata[31:0], 32'h0);
      check("x0_write_p1", rdata[63:32], 32'h0);

      tick();
      wa[0] = 7; wa[1] = 7; wd[0] = 32'h11; wd[1] = 32'h22; wen = 2'b11; ra[0] = 7; ra[1] = 5;
      tick();
      wen = 2'b00; #2;
      check("x7_port1_wins", rdata[31:0], 32'h22);

      tick();
      wa[0] = 8; wa[1] = 9; wd[0] = 32'h0808; wd[1] = 32'h0909; wen = 2'b11; ra[0] = 8; ra[1] = 9;
      tick();
      wen = 2'b00; #2;
      check("x8_dual", rdata[31:0], 32'h0808);
      check("x9_dual", rdata[63:32], 32'h0909);

      for (int i = 1; i < NREG; i += 2) begin
         wa[0] = AW'(i);     wd[0] = 32'(i) * 32'h01010101;
         wa[1] = AW'(i + 1); wd[1] = 32'(i + 1) * 32'h01010101;
         wen = {(i < NREG - 1), 1'b1};
         ra[0] = AW'(i); ra[1] = AW'(i + 1);
         tick();
      end
      wen = 2'b00; ra[0] = 31; ra[1] = 16; #2;
      check("x31_fill", rdata[31:0], 32'h1F1F1F1F);
      check("x16_fill", rdata[63:32], 32'h10101010);

      tick();
      clear = 1'b1; wa[0] = 10; wd[0] = 32'hCAFE0001; wen = 2'b01; ra[0] = 10; ra[1] = 12;
      tick();
      clear = 1'b0; wa[0] = 12; wa[1] = 13; wd[0] = 32'hBAD0; wd[1] = 32'hBAD1; wen = 2'b11;
      count_busy("busy_clear", 31);
      wen = 2'b00; #2;
      check("x10_after_clear", rdata[31:0], 32'h0);
      check("x12_dropped", rdata[63:32], 32'h0);
      for (int i = 1; i < NREG; i++) begin
         ra[0] = AW'(i);
         ra[1] = AW'(NREG - i);
         tick();
      end

      wa[0] = 20; wd[0] = 32'h55; wen = 2'b01; ra[0] = 20;
      tick();
      wen = 2'b00; #2;
      check("x20_write", rdata[31:0], 32'h55);
      tick();
      clear = 1'b1;
      tick();
      repeat (5) tick();
      clear = 1'b0;
      count_busy("busy_clear_held", 26);
      #2;
      check("x20_after_clear", rdata[31:0], 32'h0);

      tick();
      wa[0] = 4; wd[0] = 32'h77; wen = 2'b01; ra[0] = 4;
      tick();
      wen = 2'b00; clear = 1'b1;
      tick();
      clear = 1'b0;
      repeat (3) tick();
      rst_ni = 1'b0; #2;
      check("busy_mid_reset", {31'b0, busy}, 32'd1);
      tick();
      rst_ni = 1'b1;
      count_busy("busy_after_mid_reset", 31);
      #2;
      check("x4_after_reset", rdata[31:0], 32'h0);
      tick();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
